// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and round-robin helper for the LC-3 memory arbiter
package lc3_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  typedef logic port_id_t;

  // With both ports requesting, the port that was not served last wins.
  function automatic port_id_t rr_pick(input logic req0, input logic req1, input port_id_t last);
    if (req0 && req1) begin
      return port_id_t'(~last);
    end else if (req1) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/lc3_mem_arbiter.sv
// rtl/lc3_mem_arbiter.sv - two-port round-robin arbiter in front of the single-port LC-3 memory
// One transaction in flight; read latency is hidden behind a req/done handshake.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  arb_state_t               state_q, state_d;
  port_id_t                 win_q, win_d;
  port_id_t                 last_q, last_d;
  logic                     we_q, we_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [1:0]               gnt_q, gnt_d;
  logic [1:0]               done_q, done_d;
  logic [1:0][DATA_W-1:0]   rdata_q, rdata_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]        mem_wdata_q, mem_wdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_q      <= last_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Outputs are registered, so each transition loads the values seen in the state being entered.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    last_d      = last_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          win_d        = rr_pick(m0_req, m1_req, last_q);
          we_d         = win_d ? m1_we : m0_we;
          mem_addr_d   = win_d ? m1_addr : m0_addr;
          mem_wdata_d  = win_d ? m1_wdata : m0_wdata;
          mem_we_d     = we_d;
          gnt_d        = '0;
          gnt_d[win_d] = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          gnt_d         = '0;
          done_d[win_q] = 1'b1;
          state_d       = DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d[win_q] = mem_rdata;
          gnt_d          = '0;
          done_d[win_q]  = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        last_d  = win_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
